tt_sweep_capture: RTL and testbench
===================================

// Module: tt_sweep_capture
// PURPOSE
//  - Upstream driver + downstream collector for a 7-input combinational function under test (FUT).
//  - On start, applies all 2^N_IN input patterns to the FUT, one per clock, and captures each FUT output bit into a truth table.
//  - Also produces the onset count (number of 1s) for the function-classification flow.
//  - Sits between the FUT's x0..x6 inputs / out output and the classification result store.
// PARAMETERS
//  N_IN     7   number of FUT inputs; TT_W = 2**N_IN truth-table bits
//  LAT      0   FUT pipeline latency in cycles (0 = purely combinational FUT)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          request a sweep; accepted only in IDLE
//  busy       out  1          high from the cycle after start is accepted until done
//  done       out  1          one-cycle pulse when tt/onset are final
//  x          out  N_IN       pattern driven to FUT; x[0] drives x0 ... x[6] drives x6
//  f_in       in   1          FUT output bit
//  tt         out  TT_W       captured truth table; bit k = f(x==k)
//  onset      out  N_IN+1     count of 1s in tt (0..TT_W)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, x=0, tt=0, onset=0. Reset mid-sweep aborts immediately; no done.
//  - FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE.
//  - IDLE:
//      - start=1 clears tt and onset, sets pattern counter pc=0, goes to SWEEP.
//  - SWEEP:
//      - x=pc each cycle; pc increments.
//      - After x=TT_W-1 is applied: go to DRAIN if LAT>0, else to DONE.
//      - pc never wraps inside a sweep.
//  - Capture:
//      - A valid/index delay line of depth LAT tags each applied pattern.
//      - The FUT bit for pattern k is sampled at the clock edge LAT cycles after x==k is first driven; for LAT=0, the same cycle.
//      - On capture: tt[k]<=f_in; onset<=onset+f_in.
//  - DRAIN: x holds TT_W-1; stays LAT cycles until the last tagged pattern is captured, then goes to DONE.
//  - DONE: done=1 for exactly one cycle; busy=0; then IDLE.
//  - Latency: start accepted at edge E0 -> done asserted TT_W+LAT+1 cycles later (129 for defaults).
//  - busy: 1 in SWEEP and DRAIN.
//  - tt and onset: stable and held outside SWEEP/DRAIN until the next accepted start.
//  - start while busy or in DONE: ignored, no queuing.
//  - x returns to 0 in IDLE.
// CONFIGURATION
//  - TT_CHECK_EN defined:
//      - Adds input exp_tt[TT_W-1:0], sampled when start is accepted.
//      - Adds output mismatch (1b, reset 0): set in DONE iff tt != captured exp_tt; held until the next start.
//  - TT_CHECK_EN undefined: no exp_tt, no mismatch port, no compare logic.
// STRUCTURE
//  - Package tt_pkg: N_IN_DEF=7, TT_W_DEF=1<<N_IN_DEF, state enum {IDLE,SWEEP,DRAIN,DONE}.
//  - Sub-module tt_lat_pipe: LAT-deep shift register of {valid, idx[N_IN-1:0]}.
//      - Async active-low reset clears valid.
//      - LAT=0 is a pass-through.
// TESTING
//  1. f_in tied 0, default params, start pulse:
//       -> busy 128 cycles; done 129 cycles after start; tt=0; onset=0.
//  2. f_in=x[0]:
//       -> tt=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA; onset=64.
//  3. LAT=2, f_in=x[6] through two flops:
//       -> tt upper 64 bits all 1, lower 64 bits all 0; onset=64; done at 131 cycles.
//  4. start re-pulsed at cycle 40 of a sweep:
//       -> ignored; result identical to an undisturbed sweep; single done pulse.
//  5. rst_n low at cycle 60 of a sweep:
//       -> busy, x, tt, onset all 0 asynchronously; no done; a fresh start then completes normally.
//  6. TT_CHECK_EN, f_in=x[0]:
//       - exp_tt=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA -> mismatch=0.
//       - exp_tt bit 5 flipped -> mismatch=1 in the DONE cycle, held.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared sizing defaults and FSM state encoding for the truth-table sweep block.
package tt_pkg;
    localparam int N_IN_DEF = 7;
    localparam int TT_W_DEF = 1 << N_IN_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/tt_lat_pipe.sv
// LAT-deep {valid, idx} delay line that tags each applied pattern until its FUT bit is due.
// LAT=0 degenerates to a wire; only the valid bits are reset.
module tt_lat_pipe #(
    parameter int LAT = 0,
    parameter int W   = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] idx_i,
    output logic         vld_o,
    output logic [W-1:0] idx_o
);
    if (LAT == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign vld_o = vld_i;
        assign idx_o = idx_i;
    end else begin : g_pipe
        logic [LAT-1:0] vld_q;
        logic [W-1:0]   idx_q [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= vld_i;
                for (int j = 1; j < LAT; j++) vld_q[j] <= vld_q[j-1];
            end
        end

        // Index rides alongside valid; its content is irrelevant while valid is low.
        always_ff @(posedge clk) begin
            idx_q[0] <= idx_i;
            for (int j = 1; j < LAT; j++) idx_q[j] <= idx_q[j-1];
        end

        assign vld_o = vld_q[LAT-1];
        assign idx_o = idx_q[LAT-1];
    end
endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 2^N_IN patterns into the FUT and captures tt/onset; done pulses TT_W+LAT+1 cycles after start.
// No backpressure: start is ignored unless IDLE. Optional TT_CHECK_EN adds exp_tt compare and mismatch flag.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int LAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN-1:0]        x,
    input  logic                   f_in,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic [N_IN:0]          onset
`ifdef TT_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   exp_tt,
    output logic                   mismatch
`endif
);
    localparam int TT_W = 1 << N_IN;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pc_q, pc_d;
    logic [TT_W-1:0]   tt_q;
    logic [N_IN:0]     onset_q;
    logic              done_q;
    logic              start_acc;
    logic              cap_vld;
    logic [N_IN-1:0]   cap_idx;

    tt_lat_pipe #(.LAT(LAT), .W(N_IN)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (state_q == SWEEP),
        .idx_i (pc_q),
        .vld_o (cap_vld),
        .idx_o (cap_idx)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    pc_d      = '0;
                    state_d   = SWEEP;
                end
            end
            SWEEP: begin
                // pc saturates on the last pattern so DRAIN keeps driving TT_W-1.
                if (pc_q == '1) state_d = (LAT > 0) ? DRAIN : DONE;
                else            pc_d    = pc_q + 1'b1;
            end
            DRAIN: begin
                if (cap_vld && cap_idx == '1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            tt_q    <= '0;
            onset_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= (state_q == DONE);
            if (start_acc) begin
                tt_q    <= '0;
                onset_q <= '0;
            end else if (cap_vld) begin
                tt_q[cap_idx] <= f_in;
                onset_q       <= onset_q + (N_IN+1)'(f_in);
            end
        end
    end

`ifdef TT_CHECK_EN
    logic [TT_W-1:0] exp_q;
    logic            mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (start_acc) begin
            exp_q      <= exp_tt;
            mismatch_q <= 1'b0;
        end else if (state_q == DONE) begin
            mismatch_q <= (tt_q != exp_q);
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign busy  = (state_q == SWEEP) || (state_q == DRAIN);
    assign x     = busy ? pc_q : '0;
    assign done  = done_q;
    assign tt    = tt_q;
    assign onset = onset_q;
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: one LAT=0 instance with a selectable FUT and one LAT=2 instance fed x[6] through two flops.
module tb_tt_sweep_capture;
    localparam logic [127:0] TT_X0 = {64{2'b10}};
    localparam logic [127:0] TT_X6 = {{64{1'b1}}, {64{1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start0 = 1'b0, start2 = 1'b0;
    logic         sel0 = 1'b0;
    logic         busy0, done0, busy2, done2;
    logic [6:0]   x0, x2;
    logic         f0, f2;
    logic [127:0] tt0, tt2;
    logic [7:0]   onset0, onset2;
    logic         d1 = 1'b0, d2 = 1'b0;
    int           errors = 0;
    int           checks = 0;
`ifdef TT_CHECK_EN
    logic [127:0] exp0 = '0;
    logic         mm0, mm2;
`endif

    always #5 clk = ~clk;

    assign f0 = sel0 ? x0[0] : 1'b0;
    always_ff @(posedge clk) begin
        d1 <= x2[6];
        d2 <= d1;
    end
    assign f2 = d2;

    tt_sweep_capture #(.N_IN(7), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .x(x0), .f_in(f0), .tt(tt0), .onset(onset0)
`ifdef TT_CHECK_EN
        , .exp_tt(exp0), .mismatch(mm0)
`endif
    );

    tt_sweep_capture #(.N_IN(7), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .x(x2), .f_in(f2), .tt(tt2), .onset(onset2)
`ifdef TT_CHECK_EN
        , .exp_tt(128'd0), .mismatch(mm2)
`endif
    );

    // Runs one sweep on the selected instance; n counts posedges since the accepting edge.
    task automatic do_sweep(input bit which, input int restart_at, input int rst_at,
                            output int busy_cnt, output int done_cnt, output int done_at,
                            output int x_at5, output bit mm_done);
        busy_cnt = 0; done_cnt = 0; done_at = -1; x_at5 = -1; mm_done = 1'b0;
        @(negedge clk);
        if (which) start2 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        for (int n = 0; n < 140; n++) begin
            if (n > 0) @(negedge clk);
            if (which ? busy2 : busy0) busy_cnt++;
            if (n == 5) x_at5 = int'(which ? x2 : x0);
            if (which ? done2 : done0) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
`ifdef TT_CHECK_EN
                mm_done = mm0;
`endif
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            if (n == restart_at) begin
                if (which) start2 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start2 = 1'b0;
            end
        end
        start0 = 1'b0; start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done0); end
        checks++; if (x0 !== 7'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x0); end
        checks++; if (tt0 !== 128'd0) begin errors++; $display("FAIL reset_tt got=%h exp=0", tt0); end
        checks++; if (onset0 !== 8'd0) begin errors++; $display("FAIL reset_onset got=%0d exp=0", onset0); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_func();
        int bc, dc, da, x5; bit mm;
        sel0 = 1'b0;
        do_sweep(1'b0, -1, -1, bc, dc, da, x5, mm);
        checks++; if (bc !== 128) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=128", bc); end
        checks++; if (da !== 129) begin errors++; $display("FAIL zero_done_at got=%0d exp=129", da); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", dc); end
        checks++; if (x5 !== 5) begin errors++; $display("FAIL zero_x_at5 got=%0d exp=5", x5); end
        checks++; if (tt0 !== 128'd0) begin errors++; $display("FAIL zero_tt got=%h exp=0", tt0); end
        checks++; if (onset0 !== 8'd0) begin errors++; $display("FAIL zero_onset got=%0d exp=0", onset0); end
        checks++; if (x0 !== 7'd0) begin errors++; $display("FAIL zero_x_idle got=%0d exp=0", x0); end
    endtask

    task automatic test_x0_func();
        int bc, dc, da, x5; bit mm;
        sel0 = 1'b1;
        do_sweep(1'b0, -1, -1, bc, dc, da, x5, mm);
        checks++; if (tt0 !== TT_X0) begin errors++; $display("FAIL x0_tt got=%h exp=%h", tt0, TT_X0); end
        checks++; if (onset0 !== 8'd64) begin errors++; $display("FAIL x0_onset got=%0d exp=64", onset0); end
        checks++; if (da !== 129) begin errors++; $display("FAIL x0_done_at got=%0d exp=129", da); end
    endtask

    task automatic test_lat2();
        int bc, dc, da, x5; bit mm;
        do_sweep(1'b1, -1, -1, bc, dc, da, x5, mm);
        checks++; if (tt2 !== TT_X6) begin errors++; $display("FAIL lat2_tt got=%h exp=%h", tt2, TT_X6); end
        checks++; if (onset2 !== 8'd64) begin errors++; $display("FAIL lat2_onset got=%0d exp=64", onset2); end
        checks++; if (da !== 131) begin errors++; $display("FAIL lat2_done_at got=%0d exp=131", da); end
        checks++; if (bc !== 130) begin errors++; $display("FAIL lat2_busy_cycles got=%0d exp=130", bc); end
        checks++; if (x2 !== 7'd0) begin errors++; $display("FAIL lat2_x_idle got=%0d exp=0", x2); end
    endtask

    task automatic test_restart_ignored();
        int bc, dc, da, x5; bit mm;
        sel0 = 1'b1;
        do_sweep(1'b0, 40, -1, bc, dc, da, x5, mm);
        checks++; if (tt0 !== TT_X0) begin errors++; $display("FAIL restart_tt got=%h exp=%h", tt0, TT_X0); end
        checks++; if (onset0 !== 8'd64) begin errors++; $display("FAIL restart_onset got=%0d exp=64", onset0); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL restart_done_pulses got=%0d exp=1", dc); end
        checks++; if (da !== 129) begin errors++; $display("FAIL restart_done_at got=%0d exp=129", da); end
    endtask

    task automatic test_reset_mid();
        int bc, dc, da, x5, late_done; bit mm;
        sel0 = 1'b1;
        do_sweep(1'b0, -1, 60, bc, dc, da, x5, mm);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy0); end
        checks++; if (x0 !== 7'd0) begin errors++; $display("FAIL midrst_x got=%0d exp=0", x0); end
        checks++; if (tt0 !== 128'd0) begin errors++; $display("FAIL midrst_tt got=%h exp=0", tt0); end
        checks++; if (onset0 !== 8'd0) begin errors++; $display("FAIL midrst_onset got=%0d exp=0", onset0); end
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done0) late_done++;
        end
        checks++; if (late_done !== 0 || dc !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", late_done + dc); end
        rst_n = 1'b1;
        @(negedge clk);
        do_sweep(1'b0, -1, -1, bc, dc, da, x5, mm);
        checks++; if (tt0 !== TT_X0) begin errors++; $display("FAIL midrst_fresh_tt got=%h exp=%h", tt0, TT_X0); end
        checks++; if (onset0 !== 8'd64) begin errors++; $display("FAIL midrst_fresh_onset got=%0d exp=64", onset0); end
        checks++; if (da !== 129) begin errors++; $display("FAIL midrst_fresh_done_at got=%0d exp=129", da); end
    endtask

`ifdef TT_CHECK_EN
    task automatic test_check();
        int bc, dc, da, x5; bit mm;
        sel0 = 1'b1;
        exp0 = TT_X0;
        do_sweep(1'b0, -1, -1, bc, dc, da, x5, mm);
        checks++; if (mm !== 1'b0) begin errors++; $display("FAIL chk_match_at_done got=%0b exp=0", mm); end
        checks++; if (mm0 !== 1'b0) begin errors++; $display("FAIL chk_match_held got=%0b exp=0", mm0); end
        exp0 = TT_X0 ^ (128'd1 << 5);
        do_sweep(1'b0, -1, -1, bc, dc, da, x5, mm);
        checks++; if (mm !== 1'b1) begin errors++; $display("FAIL chk_bit5_at_done got=%0b exp=1", mm); end
        checks++; if (mm0 !== 1'b1) begin errors++; $display("FAIL chk_bit5_held got=%0b exp=1", mm0); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_func();
        test_x0_func();
        test_lat2();
        test_restart_ignored();
        test_reset_mid();
`ifdef TT_CHECK_EN
        test_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
